// File: rtl/riscv_x_pkg.sv
// riscv_x_pkg: shared opcode/funct3 constants, history entry and flush-state types
// for the RV32 execute-stage forwarding/control slice.
`default_nettype none

package riscv_x_pkg;

   localparam logic [6:0] c_OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] c_OPC_STORE   = 7'b0100011;
   localparam logic [6:0] c_OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] c_OPC_JAL     = 7'b1101111;
   localparam logic [6:0] c_OPC_JALR    = 7'b1100111;
   localparam logic [6:0] c_OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] c_OPC_OP      = 7'b0110011;
   localparam logic [6:0] c_OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] c_OPC_OP32    = 7'b0111011;

   localparam logic [2:0] c_F3_BEQ  = 3'b000;
   localparam logic [2:0] c_F3_BNE  = 3'b001;
   localparam logic [2:0] c_F3_BLT  = 3'b100;
   localparam logic [2:0] c_F3_BGE  = 3'b101;
   localparam logic [2:0] c_F3_BLTU = 3'b110;
   localparam logic [2:0] c_F3_BGEU = 3'b111;

   localparam logic [2:0] c_F3_SB = 3'b000;
   localparam logic [2:0] c_F3_SH = 3'b001;
   localparam logic [2:0] c_F3_SW = 3'b010;
   localparam logic [2:0] c_F3_SD = 3'b011;

   // Sized for the widest supported XLEN; narrower builds use the low bits.
   localparam int c_HIST_DW = 64;

   typedef struct packed {
      logic                 valid;
      logic [4:0]           rd;
      logic [c_HIST_DW-1:0] data;
      logic                 pending;
   } hist_entry_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } flush_state_t;

   function automatic logic reads_rs1(input logic [6:0] opc);
      case (opc)
         c_OPC_LOAD, c_OPC_STORE, c_OPC_BRANCH, c_OPC_JALR,
         c_OPC_OPIMM, c_OPC_OP, c_OPC_OPIMM32, c_OPC_OP32: reads_rs1 = 1'b1;
         default:                                          reads_rs1 = 1'b0;
      endcase
   endfunction

   function automatic logic reads_rs2(input logic [6:0] opc);
      case (opc)
         c_OPC_STORE, c_OPC_BRANCH, c_OPC_OP, c_OPC_OP32: reads_rs2 = 1'b1;
         default:                                        reads_rs2 = 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/x_store_align.sv
// x_store_align: combinational store lane replication and byte-mask generation.
`default_nettype none

module x_store_align
   import riscv_x_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic                         i_en,
   input  logic [2:0]                   i_funct3,
   input  logic [XLEN-1:0]              i_data,
   input  logic [$clog2(XLEN/8)-1:0]    i_offset,
   output logic [XLEN-1:0]              o_data,
   output logic [XLEN/8-1:0]            o_mask
);

   localparam int NB = XLEN / 8;

   logic [XLEN-1:0] w_rep;
   logic [NB-1:0]   w_base;
   logic            w_ok;

   always_comb begin
      w_rep  = i_data;
      w_base = '0;
      w_ok   = 1'b0;
      case (i_funct3)
         c_F3_SB: begin
            w_rep  = {NB{i_data[7:0]}};
            w_base = NB'(1);
            w_ok   = 1'b1;
         end
         c_F3_SH: begin
            w_rep  = {(NB/2){i_data[15:0]}};
            w_base = NB'(3);
            w_ok   = (i_offset[0] == 1'b0);
         end
         c_F3_SW: begin
            w_rep  = {(NB/4){i_data[31:0]}};
            w_base = NB'(15);
            w_ok   = (i_offset[1:0] == 2'b00);
         end
         c_F3_SD: begin
            if (XLEN == 64) begin
               w_base = '1;
               w_ok   = (i_offset == '0);
            end
         end
         default: ;
      endcase
   end

   assign o_data = w_rep << {i_offset, 3'b000};
   assign o_mask = (i_en && w_ok) ? (w_base << i_offset) : '0;

endmodule

`default_nettype wire

// File: rtl/x_fwd_ctrl.sv
// x_fwd_ctrl: execute-stage forwarding, load-use stall, branch resolve and flush control.
// Optional X_FWD_STATS_EN adds saturating fwd_hits/stall_cycles/flush_cycles counters.
`default_nettype none

module x_fwd_ctrl
   import riscv_x_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int FWD_DEPTH    = 2,
   parameter int FLUSH_CYCLES = 1
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       x_valid,
   input  logic [31:0]                x_inst,
   input  logic [XLEN-1:0]            rs1_rf_data,
   input  logic [XLEN-1:0]            rs2_rf_data,
   input  logic [XLEN-1:0]            x_result,
   input  logic                       load_data_valid,
   input  logic [XLEN-1:0]            load_data,
   input  logic [$clog2(XLEN/8)-1:0]  addr_offset,
   output logic [XLEN-1:0]            fwd_rs1,
   output logic [XLEN-1:0]            fwd_rs2,
   output logic                       pc_sel,
   output logic                       stall,
   output logic                       flush,
   output logic [XLEN-1:0]            store_data,
   output logic [XLEN/8-1:0]          store_mask
`ifdef X_FWD_STATS_EN
   ,
   output logic [31:0]                fwd_hits,
   output logic [31:0]                stall_cycles,
   output logic [31:0]                flush_cycles
`endif
);

   logic [6:0] w_opc;
   logic [4:0] w_rd, w_rs1, w_rs2;
   logic [2:0] w_funct3;

   assign w_opc    = x_inst[6:0];
   assign w_rd     = x_inst[11:7];
   assign w_funct3 = x_inst[14:12];
   assign w_rs1    = x_inst[19:15];
   assign w_rs2    = x_inst[24:20];

   hist_entry_t  r_hist [FWD_DEPTH];
   hist_entry_t  w_shift [FWD_DEPTH];
   hist_entry_t  w_next [FWD_DEPTH];
   flush_state_t r_state;
   logic [1:0]   r_cnt;

   logic                 w_hit1, w_hit2, w_pend1, w_pend2;
   logic [c_HIST_DW-1:0] w_hdat1, w_hdat2;
   logic [XLEN-1:0]      w_src1, w_src2;
   logic                 w_uses1, w_uses2, w_writer, w_push;
   logic                 w_stall, w_flush, w_br_taken, w_redirect, w_pc_sel;
   logic                 w_unused;

   assign w_unused = ^{x_inst[31:25], w_hdat1, w_hdat2};

   // Oldest-to-youngest scan so the youngest match overwrites older ones.
   always_comb begin
      w_hit1 = 1'b0; w_pend1 = 1'b0; w_hdat1 = '0;
      w_hit2 = 1'b0; w_pend2 = 1'b0; w_hdat2 = '0;
      for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
         if (r_hist[i].valid && r_hist[i].rd == w_rs1 && w_rs1 != 5'd0) begin
            w_hit1 = 1'b1; w_pend1 = r_hist[i].pending; w_hdat1 = r_hist[i].data;
         end
         if (r_hist[i].valid && r_hist[i].rd == w_rs2 && w_rs2 != 5'd0) begin
            w_hit2 = 1'b1; w_pend2 = r_hist[i].pending; w_hdat2 = r_hist[i].data;
         end
      end
   end

   always_comb begin
      if (w_rs1 == 5'd0)  w_src1 = '0;
      else if (w_hit1)    w_src1 = w_pend1 ? load_data : w_hdat1[XLEN-1:0];
      else                w_src1 = rs1_rf_data;
      if (w_rs2 == 5'd0)  w_src2 = '0;
      else if (w_hit2)    w_src2 = w_pend2 ? load_data : w_hdat2[XLEN-1:0];
      else                w_src2 = rs2_rf_data;
   end

   assign w_uses1  = reads_rs1(w_opc);
   assign w_uses2  = reads_rs2(w_opc);
   assign w_writer = (w_opc != c_OPC_BRANCH) && (w_opc != c_OPC_STORE) && (w_rd != 5'd0);
   assign w_flush  = (r_state == FLUSH);
   assign w_stall  = !reset && x_valid && !load_data_valid &&
                     ((w_uses1 && w_hit1 && w_pend1) || (w_uses2 && w_hit2 && w_pend2));
   assign w_push   = x_valid && !w_stall && !w_flush;

   always_comb begin
      case (w_funct3)
         c_F3_BEQ:  w_br_taken = (w_src1 == w_src2);
         c_F3_BNE:  w_br_taken = (w_src1 != w_src2);
         c_F3_BLT:  w_br_taken = ($signed(w_src1) <  $signed(w_src2));
         c_F3_BGE:  w_br_taken = ($signed(w_src1) >= $signed(w_src2));
         c_F3_BLTU: w_br_taken = (w_src1 <  w_src2);
         c_F3_BGEU: w_br_taken = (w_src1 >= w_src2);
         default:   w_br_taken = 1'b0;
      endcase
   end

   assign w_redirect = ((w_opc == c_OPC_BRANCH) && w_br_taken) ||
                       (w_opc == c_OPC_JAL) || (w_opc == c_OPC_JALR);
   assign w_pc_sel   = w_push && w_redirect;

   // Load fill lands on the post-shift history, youngest pending entry first.
   always_comb begin : p_hist_next
      logic l_done;
      w_shift = r_hist;
      if (w_push) begin
         for (int i = FWD_DEPTH - 1; i > 0; i--)
            w_shift[i] = r_hist[i-1];
         w_shift[0].valid              = w_writer;
         w_shift[0].rd                 = w_rd;
         w_shift[0].data               = '0;
         w_shift[0].data[XLEN-1:0]     = x_result;
         w_shift[0].pending            = (w_opc == c_OPC_LOAD);
      end
      w_next = w_shift;
      l_done = 1'b0;
      for (int i = 0; i < FWD_DEPTH; i++) begin
         if (load_data_valid && !l_done && w_shift[i].valid && w_shift[i].pending) begin
            w_next[i].pending        = 1'b0;
            w_next[i].data           = '0;
            w_next[i].data[XLEN-1:0] = load_data;
            l_done                   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FWD_DEPTH; i++)
            r_hist[i] <= '0;
         r_state <= IDLE;
         r_cnt   <= 2'd0;
      end else begin
         for (int i = 0; i < FWD_DEPTH; i++)
            r_hist[i] <= w_next[i];
         case (r_state)
            IDLE: begin
               if (w_pc_sel) begin
                  r_state <= FLUSH;
                  r_cnt   <= 2'd0;
               end
            end
            FLUSH: begin
               if (r_cnt == 2'(FLUSH_CYCLES - 1)) r_state <= IDLE;
               else                                r_cnt   <= r_cnt + 2'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign fwd_rs1 = reset ? '0 : w_src1;
   assign fwd_rs2 = reset ? '0 : w_src2;
   assign stall   = w_stall;
   assign flush   = w_flush && !reset;
   assign pc_sel  = w_pc_sel && !reset;

   x_store_align #(.XLEN(XLEN)) u_store_align (
      .i_en     (!reset && x_valid && (w_opc == c_OPC_STORE) && !w_stall && !w_flush),
      .i_funct3 (w_funct3),
      .i_data   (w_src2),
      .i_offset (addr_offset),
      .o_data   (store_data),
      .o_mask   (store_mask)
   );

`ifdef X_FWD_STATS_EN
   logic [31:0] r_fwd_hits, r_stall_cycles, r_flush_cycles;
   logic        w_hit_any;

   assign w_hit_any = x_valid && ((w_uses1 && w_hit1) || (w_uses2 && w_hit2));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fwd_hits     <= '0;
         r_stall_cycles <= '0;
         r_flush_cycles <= '0;
      end else begin
         if (w_hit_any && r_fwd_hits != '1)     r_fwd_hits     <= r_fwd_hits + 32'd1;
         if (w_stall && r_stall_cycles != '1)   r_stall_cycles <= r_stall_cycles + 32'd1;
         if (w_flush && r_flush_cycles != '1)   r_flush_cycles <= r_flush_cycles + 32'd1;
      end
   end

   assign fwd_hits     = r_fwd_hits;
   assign stall_cycles = r_stall_cycles;
   assign flush_cycles = r_flush_cycles;
`endif

endmodule

`default_nettype wire

// File: doc/x_fwd_ctrl.md
Name: x_fwd_ctrl

Overview:
- Parametrised execute-stage control and forwarding unit for the RV32 pipeline.
- Keeps a registered history of the last FWD_DEPTH retired writers (rd, value, pending-load flag) and forwards operands to X from that history.
- Resolves branches and jumps, generates a load-use stall and a multi-cycle flush sequence, and aligns store data and byte mask for XLEN-wide memory.
- Sits between the decode pipeline register and the ALU/DMem interface; it is the sole source of PC redirect and flush.

Parameters:
- XLEN, 32, datapath width; must be 32 or 64.
- FWD_DEPTH, 2, number of history entries searched for forwarding (1..4).
- FLUSH_CYCLES, 1, number of cycles flush stays asserted after a redirect (1..3).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high.
- x_valid  input  1  X holds a real instruction.
- x_inst  input  32  instruction in X.
- rs1_rf_data  input  XLEN  register-file rs1 value.
- rs2_rf_data  input  XLEN  register-file rs2 value.
- x_result  input  XLEN  ALU result of the current X instruction.
- load_data_valid  input  1  DMem load data returned this cycle.
- load_data  input  XLEN  aligned, extended load value.
- addr_offset  input  $clog2(XLEN/8)  low bits of the store address.
- fwd_rs1  output  XLEN  forwarded rs1.
- fwd_rs2  output  XLEN  forwarded rs2.
- pc_sel  output  1  redirect PC (taken branch, JAL, JALR).
- stall  output  1  hold F/D/X this cycle.
- flush  output  1  squash younger instructions.
- store_data  output  XLEN  lane-shifted store value.
- store_mask  output  XLEN/8  byte write enable.

Behaviour:
- Reset: every history entry becomes invalid; the flush FSM returns to IDLE; stall=0, flush=0, pc_sel=0, store_mask=0, fwd_rs*=0.
- Writer: an instruction whose opcode is not BRANCH or STORE and whose rd≠0.
- History push: when x_valid && !stall && !flush, entry0 takes {rd, x_result, pending=(opcode==LOAD)} and older entries shift; otherwise the history holds. Entries beyond FWD_DEPTH drop off.
- Load fill: load_data_valid fills the youngest pending entry with load_data and clears its pending flag. This happens in the same cycle as any push, and the fill targets the entry after the shift.
- Forwarding:
  - Combinational search, youngest match wins.
  - A match requires a valid entry, rd==rs and rs≠0.
  - If nothing matches, the RF value is used.
  - x0 always reads 0.
- Load-use stall: stall=1 when the youngest matching entry for rs1 or rs2 (only for opcodes that read the register) is pending and load_data_valid=0 this cycle.
  - If load_data_valid=1 this cycle, load_data is forwarded directly, with no stall.
- Branch:
  - Signed/unsigned compare of fwd_rs1 and fwd_rs2 per funct3: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - An invalid funct3 is treated as not taken.
  - pc_sel=1 for a taken branch, JAL or JALR, gated by x_valid && !stall && !flush.
- Flush FSM:
  - IDLE→FLUSH on pc_sel.
  - FLUSH counts FLUSH_CYCLES cycles with flush=1, then returns to IDLE.
  - pc_sel is suppressed while in FLUSH, because the X instruction is squashed.
  - Reset mid-FLUSH returns the FSM to IDLE immediately.
- Store:
  - SB, SH and SW (and SD when XLEN=64) replicate the value into lanes and shift it by addr_offset.
  - store_mask is (1<<size)-1 shifted by addr_offset.
  - A misaligned half or word gives store_mask=0.
  - store_mask=0 for non-stores, and also while stall or flush is asserted.
- Simultaneous events: stall takes priority over pc_sel; reset takes priority over everything.

Optional Feature:
- Macro: X_FWD_STATS_EN.
- When defined, the block adds three 32-bit saturating counters: fwd_hits, stall_cycles and flush_cycles.
- The counters clear on reset and are exposed as extra output ports.
- When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package riscv_x_pkg: opcode and funct3 constants, the hist_entry_t struct {valid, rd[4:0], data, pending}, and the flush_state_t enum {IDLE, FLUSH}.
- Sub-module x_store_align (combinational store lane/mask generator), parametrised by XLEN.

Test Plan:
- addi x5,x0,7 then add x6,x5,x5 → fwd_rs1=fwd_rs2=7 from entry0, stall=0.
- lw x5 with load_data_valid arriving 1 cycle late, then add x6,x5,x0 → stall=1 for one cycle, then fwd_rs1 equals load_data.
- Two writers to x5 (values 3 then 9), then a use → fwd_rs1=9, because the youngest entry wins. A writer to x0 followed by a use of x0 → 0.
- blt with x1=-1, x2=1 → pc_sel=1 and flush=1 for exactly FLUSH_CYCLES. bltu with the same values → not taken.
- sb with value 0xAB at offset 3 (XLEN=32) → store_mask=4'b1000, store_data=0xAB000000. sh at offset 1 → store_mask=0.
- Reset asserted during FLUSH with a pending history entry → next cycle flush=0, all entries invalid, and a following use of the same register reads RF data.
